// File: rtl/ls138_scan_ctrl_if.sv
// Control bundle between the scan controller and the 3-to-8 decoder it drives.
// The master side supplies en/mask; the slave (controller) drives the decoder pins.
interface ls138_scan_ctrl_if;
  logic       en;
  logic [7:0] mask;
  logic       C;
  logic       B;
  logic       A;
  logic       G;
  logic       G2A;
  logic       G2B;
  logic [2:0] digit_idx;
  logic       digit_strobe;

  modport master (
    output en, mask,
    input  C, B, A, G, G2A, G2B, digit_idx, digit_strobe
  );

  modport slave (
    input  en, mask,
    output C, B, A, G, G2A, G2B, digit_idx, digit_strobe
  );
endinterface

// File: rtl/ls138_scan_ctrl.sv
// Scan controller for a 3-to-8 decoder: steps through the masked lines, holding each
// for DWELL_CYC cycles, with a BLANK_CYC-cycle decoder-disabled gap before every line.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | decoder blanked, address held, waiting for en and mask!=0
// S_BLANK | decoder blanked, new address settling
// S_DWELL | decoder active on the current line
module ls138_scan_ctrl #(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ls138_scan_ctrl_if.slave    bus
);

  localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CW-1:0] DWELL_TC = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    addr_q, addr_d;
  logic          act_q, act_d;
  logic          dis_q, dis_d;
  logic          strobe_q, strobe_d;

  function automatic logic [2:0] first_line(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Scanning offsets downward lets the nearest set bit above p win; offset 8 wraps to p.
  function automatic logic [2:0] next_line(input logic [2:0] p, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] c;
    r = p;
    for (int i = 8; i >= 1; i--) begin
      c = p + 3'(i);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.en && (bus.mask != 8'h00)) begin
          state_d = S_BLANK;
          addr_d  = first_line(bus.mask);
        end
      end
      S_BLANK: begin
        if (!bus.en)                state_d = S_IDLE;
        else if (cnt_q == BLANK_TC) state_d = S_DWELL;
      end
      S_DWELL: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (cnt_q == DWELL_TC) begin
          if (bus.mask != 8'h00) begin
            state_d = S_BLANK;
            addr_d  = next_line(addr_q, bus.mask);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    act_d    = (state_d == S_DWELL);
    dis_d    = (state_d != S_DWELL);
    strobe_d = (state_d == S_DWELL) && (state_q != S_DWELL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= 3'd0;
      act_q    <= 1'b0;
      dis_q    <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      act_q    <= act_d;
      dis_q    <= dis_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.C            = addr_q[2];
  assign bus.B            = addr_q[1];
  assign bus.A            = addr_q[0];
  assign bus.digit_idx    = addr_q;
  assign bus.G            = act_q;
  assign bus.G2A          = dis_q;
  assign bus.G2B          = dis_q;
  assign bus.digit_strobe = strobe_q;

endmodule
